stage_sequencer: RTL and testbench

- Multicycle control FSM for the single-issue core.
- Produces the stage code consumed by the writeback/PC-update logic.
- Runs the instruction-fetch and data-memory request/acknowledge handshakes.
- Emits the one-cycle strobes that latch the instruction register and write-back data and commit the register file and PC.

---
 rtl/stage_sequencer_if.sv | 45 ++++
 rtl/stage_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : stage_sequencer_if
// Brief  : Handshake/strobe bundle between the stage sequencer and the core.
//          Carries retire_cnt_o when STAGE_SEQ_RETIRE_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
interface stage_sequencer_if;
    logic        run_i;
    logic [31:0] ir_i;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ack_i;
    logic        ir_load_o;
    logic        wd_q_readin_o;
    logic        rf_we_o;
    logic        pc_we_o;
    logic [2:0]  stage_o;
    logic        halt_o;
    logic [1:0]  fault_o;
`ifdef STAGE_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt_o;
`endif

    modport master (
        input  run_i, ir_i, imem_ack_i, dmem_ack_i,
        output imem_req_o, dmem_req_o, dmem_we_o, ir_load_o, wd_q_readin_o,
               rf_we_o, pc_we_o, stage_o, halt_o, fault_o
`ifdef STAGE_SEQ_RETIRE_CNT_EN
        , output retire_cnt_o
`endif
    );

    modport slave (
        output run_i, ir_i, imem_ack_i, dmem_ack_i,
        input  imem_req_o, dmem_req_o, dmem_we_o, ir_load_o, wd_q_readin_o,
               rf_we_o, pc_we_o, stage_o, halt_o, fault_o
`ifdef STAGE_SEQ_RETIRE_CNT_EN
        , input retire_cnt_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : stage_sequencer
// Brief  : Multicycle FETCH/DECODE/EXEC/MEM/WRITE control FSM with memory
//          handshakes, ack timeouts and sticky fault reporting.
//          Optional retire counter enabled by STAGE_SEQ_RETIRE_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    stage_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_L     = 7'b0000011;
    localparam logic [6:0] c_OP_S     = 7'b0100011;
    localparam logic [6:0] c_OP_B     = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    localparam logic [1:0] c_FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] c_FAULT_IMEM    = 2'd2;
    localparam logic [1:0] c_FAULT_DMEM    = 2'd3;

    localparam logic [TO_W:0] c_TO_LIMIT = (TO_W+1)'(MEM_TIMEOUT);
    localparam bit            c_TO_EN    = (MEM_TIMEOUT != 0);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic [1:0]      r_fault;
    logic            r_halt;
    logic            r_imem_req;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic            r_wd;
    logic            r_rf_we;
    logic            r_pc_we;

    logic [6:0]      w_opcode;
    logic            w_legal;
    logic            w_wb;
    logic            w_rf_we;
    logic            w_is_ls;
    logic            w_is_store;
    logic [TO_W:0]   w_cnt_inc;
    logic            w_to_hit;
    logic            w_unused_ir;

    assign w_opcode    = bus.ir_i[6:0];
    assign w_is_store  = (w_opcode == c_OP_S);
    assign w_is_ls     = (w_opcode == c_OP_L) || w_is_store;
    assign w_rf_we     = w_wb && (bus.ir_i[11:7] != 5'd0);
    assign w_unused_ir = ^bus.ir_i[31:12];

    always_comb begin
        w_legal = 1'b0;
        w_wb    = 1'b0;
        case (w_opcode)
            c_OP_R, c_OP_I, c_OP_L, c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR: begin
                w_legal = 1'b1;
                w_wb    = 1'b1;
            end
            c_OP_S, c_OP_B: w_legal = 1'b1;
            default: ;
        endcase
    end

    // The request is allowed as many cycles as MEM_TIMEOUT; an ack in the
    // cycle whose increment would reach the limit is still accepted.
    assign w_cnt_inc = {1'b0, r_cnt} + {{TO_W{1'b0}}, 1'b1};
    assign w_to_hit  = c_TO_EN && (w_cnt_inc == c_TO_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_fault    <= 2'd0;
            r_halt     <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_wd       <= 1'b0;
            r_rf_we    <= 1'b0;
            r_pc_we    <= 1'b0;
        end else begin
            r_wd    <= 1'b0;
            r_rf_we <= 1'b0;
            r_pc_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.run_i) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.imem_ack_i) begin
                        r_state    <= ST_DECODE;
                        r_imem_req <= 1'b0;
                    end else if (w_to_hit) begin
                        r_state    <= ST_HALT;
                        r_imem_req <= 1'b0;
                        r_halt     <= 1'b1;
                        r_fault    <= c_FAULT_IMEM;
                    end else begin
                        r_cnt      <= w_cnt_inc[TO_W-1:0];
                    end
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                        r_fault <= c_FAULT_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    if (w_is_ls) begin
                        r_state    <= ST_MEM;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= w_is_store;
                        r_cnt      <= '0;
                    end else begin
                        r_state <= ST_WRITE;
                        r_wd    <= w_wb;
                        r_rf_we <= w_rf_we;
                        r_pc_we <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_ack_i) begin
                        r_state    <= ST_WRITE;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_wd       <= w_wb;
                        r_rf_we    <= w_rf_we;
                        r_pc_we    <= 1'b1;
                    end else if (w_to_hit) begin
                        r_state    <= ST_HALT;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_halt     <= 1'b1;
                        r_fault    <= c_FAULT_DMEM;
                    end else begin
                        r_cnt      <= w_cnt_inc[TO_W-1:0];
                    end
                end
                ST_WRITE: begin
                    if (bus.run_i) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_HALT: ;
                default: begin
                    r_state    <= ST_HALT;
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_dmem_we  <= 1'b0;
                    r_halt     <= 1'b1;
                    r_fault    <= c_FAULT_ILLEGAL;
                end
            endcase
        end
    end

    assign bus.imem_req_o    = r_imem_req;
    assign bus.dmem_req_o    = r_dmem_req;
    assign bus.dmem_we_o     = r_dmem_we;
    assign bus.wd_q_readin_o = r_wd;
    assign bus.rf_we_o       = r_rf_we;
    assign bus.pc_we_o       = r_pc_we;
    assign bus.stage_o       = r_state;
    assign bus.halt_o        = r_halt;
    assign bus.fault_o       = r_fault;

    // The instruction word is only on the bus during the ack cycle, so the
    // IR load must coincide with it rather than trail it by a register stage.
    assign bus.ir_load_o = (r_state == ST_FETCH) && bus.imem_ack_i;

`ifdef STAGE_SEQ_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= 32'd0;
        end else if (r_pc_we) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.retire_cnt_o = r_retire_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_stage_sequencer
// Brief  : Self-checking bench: per-cycle expectations built from
//          instruction-level rules, then directed reset/retire sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_stage_sequencer;
    localparam int          TB_TO   = 4;
    localparam logic [31:0] c_ADD   = 32'h002081B3;
    localparam logic [31:0] c_LW    = 32'h0000A103;
    localparam logic [31:0] c_SW    = 32'h0020A023;
    localparam logic [31:0] c_ADDI0 = 32'h00000013;
    localparam logic [31:0] c_BEQ   = 32'h00000063;
    localparam logic [31:0] c_ILL   = 32'h0000007F;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stage_sequencer_if bus ();

    stage_sequencer #(.MEM_TIMEOUT(TB_TO), .TO_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // outs bit order: {imem_req, dmem_req, dmem_we, ir_load, wd, rf_we, pc_we, halt}
    typedef struct {
        logic        rst;
        logic        run;
        logic        iack;
        logic        dack;
        logic [31:0] ir;
        logic        chk;
        logic [2:0]  stage;
        logic [7:0]  outs;
        logic [1:0]  fault;
    } vec_t;

    vec_t        plan[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_ir;
    logic [31:0] m_ret;
    logic [6:0]  legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                   7'b1100111};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 illegal, 1 writes back, 2 store, 3 branch
    function automatic int op_class(logic [31:0] ir);
        case (ir[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 1;
            7'b0100011: return 2;
            7'b1100011: return 3;
            default:    return 0;
        endcase
    endfunction

    function automatic void add(logic rst, logic run, logic iack, logic dack,
                                logic [2:0] st, logic [7:0] o, logic [1:0] f, logic chk);
        vec_t v;
        v.rst = rst; v.run = run; v.iack = iack; v.dack = dack; v.ir = cur_ir;
        v.chk = chk; v.stage = st; v.outs = o; v.fault = f;
        plan.push_back(v);
    endfunction

    // Sticky HALT that ignores run, then reset back to IDLE and restart.
    function automatic void halt_seq(logic [1:0] f);
        for (int k = 0; k < 3; k++) add(0, rb(), rb(), rb(), 3'd7, 8'b0000_0001, f, 1);
        add(1, 0, rb(), rb(), 3'd7, 8'b0000_0001, f, 1);
        add(0, 0, rb(), rb(), 3'd0, 8'h00, 2'd0, 1);
        add(0, 1, rb(), rb(), 3'd0, 8'h00, 2'd0, 1);
    endfunction

    // One instruction starting in its first FETCH cycle; leaves the plan
    // positioned so the next cycle is a FETCH again.
    function automatic void gen_instr(logic [31:0] ir, int iw, int dw,
                                      bit run_mid, bit run_wr, int idle_n);
        int   cls = op_class(ir);
        bit   mem = (ir[6:0] == 7'b0000011) || (ir[6:0] == 7'b0100011);
        logic wd  = (cls == 1);
        logic rf  = (cls == 1) && (ir[11:7] != 5'd0);
        logic we  = (cls == 2);
        cur_ir = ir;
        for (int k = 0; k < iw && k < TB_TO; k++)
            add(0, run_mid & rb(), 0, rb(), 3'd1, 8'b1000_0000, 2'd0, 1);
        if (iw >= TB_TO) begin
            halt_seq(2'd2);
            return;
        end
        add(0, run_mid & rb(), 1, rb(), 3'd1, 8'b1001_0000, 2'd0, 1);
        add(0, run_mid & rb(), rb(), rb(), 3'd2, 8'h00, 2'd0, 1);
        if (cls == 0) begin
            halt_seq(2'd1);
            return;
        end
        add(0, run_mid & rb(), rb(), rb(), 3'd3, 8'h00, 2'd0, 1);
        if (mem) begin
            for (int k = 0; k < dw && k < TB_TO; k++)
                add(0, run_mid & rb(), rb(), 0, 3'd4, {2'b01, we, 5'b0}, 2'd0, 1);
            if (dw >= TB_TO) begin
                halt_seq(2'd3);
                return;
            end
            add(0, run_mid & rb(), rb(), 1, 3'd4, {2'b01, we, 5'b0}, 2'd0, 1);
        end
        add(0, run_wr, rb(), rb(), 3'd5, {4'b0, wd, rf, 1'b1, 1'b0}, 2'd0, 1);
        if (!run_wr) begin
            for (int k = 0; k < idle_n; k++) add(0, 0, rb(), rb(), 3'd0, 8'h00, 2'd0, 1);
            add(0, 1, rb(), rb(), 3'd0, 8'h00, 2'd0, 1);
        end
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.run_i = 1'b0; bus.ir_i = 32'd0; bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b0;
        cur_ir = 32'd0;
        m_ret  = 32'd0;

        add(1, 0, 0, 0, 3'd0, 8'h00, 2'd0, 0);
        add(1, 0, 0, 0, 3'd0, 8'h00, 2'd0, 1);
        add(0, 0, 0, 0, 3'd0, 8'h00, 2'd0, 1);
        add(0, 1, 0, 0, 3'd0, 8'h00, 2'd0, 1);

        gen_instr(c_ADD,   0, 0, 1, 1, 0);
        gen_instr(c_LW,    2, 3, 1, 1, 0);
        gen_instr(c_SW,    0, 1, 1, 1, 0);
        gen_instr(c_ADDI0, 1, 0, 0, 0, 2);
        gen_instr(c_BEQ,   3, 0, 1, 1, 0);
        gen_instr(c_LW,    0, 4, 1, 1, 0);
        gen_instr(c_ILL,   0, 0, 1, 1, 0);
        gen_instr(c_ADD,   4, 0, 1, 1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ir;
            int          iw;
            int          dw;
            ir = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                while (op_class(ir) != 0) ir[6:0] = 7'($urandom);
            end else begin
                ir[6:0] = legal_ops[$urandom_range(0, 8)];
            end
            if ($urandom_range(0, 3) == 0) ir[11:7] = 5'd0;
            iw = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 3) : TB_TO;
            dw = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 3) : TB_TO;
            gen_instr(ir, iw, dw, rb(), rb(), $urandom_range(0, 2));
        end

        for (int i = 0; i < plan.size(); i++) begin
            reset          = plan[i].rst;
            bus.run_i      = plan[i].run;
            bus.imem_ack_i = plan[i].iack;
            bus.dmem_ack_i = plan[i].dack;
            bus.ir_i       = plan[i].ir;
            @(negedge clk);
            if (plan[i].chk) begin
                check($sformatf("vec[%0d]", i),
                      {bus.stage_o, bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o,
                       bus.ir_load_o, bus.wd_q_readin_o, bus.rf_we_o, bus.pc_we_o,
                       bus.halt_o, bus.fault_o},
                      {plan[i].stage, plan[i].outs, plan[i].fault});
`ifdef STAGE_SEQ_RETIRE_CNT_EN
                check($sformatf("retire[%0d]", i), bus.retire_cnt_o, m_ret);
`endif
            end
            if (plan[i].rst)          m_ret = 32'd0;
            else if (plan[i].outs[1]) m_ret = m_ret + 32'd1;
            @(posedge clk); #1;
        end

        // Reset asserted while a data request is outstanding.
        reset = 1'b1; bus.run_i = 1'b0; bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; bus.run_i = 1'b1; bus.ir_i = c_LW; bus.imem_ack_i = 1'b1;
        for (int k = 0; k < 10 && bus.stage_o != 3'd4; k++) begin
            @(posedge clk); #1;
        end
        check("reach_mem", bus.stage_o, 3'd4);
        check("mem_req", bus.dmem_req_o, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mem_stage", bus.stage_o, 3'd0);
        check("rst_mem_req", bus.dmem_req_o, 1'b0);

`ifdef STAGE_SEQ_RETIRE_CNT_EN
        // Three back-to-back zero-wait ADDs, then a wrap of the counter.
        bus.ir_i = c_ADD;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check("retire_3", bus.retire_cnt_o, 32'd3);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_retire_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("retire_wrap", bus.retire_cnt_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
